// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer between a 2-wide fetch stage and a
// 2-wide decode stage, with advisory back-pressure and a sticky overflow flag.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              I1,
    input  logic [15:0]              I2,
    input  logic                     I1V,
    input  logic                     I2V,
    input  logic                     I1P,
    input  logic                     I2P,
    input  logic [15:0]              I1PC,
    input  logic [15:0]              I2PC,
    input  logic                     flush,
    input  logic [1:0]               take,
    output logic [15:0]              D0,
    output logic [15:0]              D1,
    output logic                     D0V,
    output logic                     D1V,
    output logic                     D0P,
    output logic                     D1P,
    output logic [15:0]              D0PC,
    output logic [15:0]              D1PC,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: fetch has no ready; every valid slot is sampled at each edge and
    // stall is back-pressure honoured one cycle late. Decode consumes via take,
    // which is clamped to the occupancy.
    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [1:0]    take_eff, enq, acc;
    logic [CW-1:0] deq, free_slots;
    logic [32:0]   slot0, slot1;
    logic          wr0, wr1;
    logic [AW-1:0] tail_inc, head_inc;
    logic [32:0]   e0, e1;

    always_comb begin
        take_eff   = (take == 2'd3) ? 2'd2 : take;
        deq        = (CW'(take_eff) > count_q) ? count_q : CW'(take_eff);
        free_slots = CW'(DEPTH) - count_q + deq;
        enq        = {1'b0, I1V} + {1'b0, I2V};
        // Excess only arises when fewer than two slots are free, so the low bits suffice.
        acc        = (CW'(enq) > free_slots) ? free_slots[1:0] : enq;
        slot0      = I1V ? {I1, I1P, I1PC} : {I2, I2P, I2PC};
        slot1      = {I2, I2P, I2PC};

        wr0        = 1'b0;
        wr1        = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            wr0        = (acc != 2'd0);
            wr1        = (acc == 2'd2);
            head_d     = head_q + deq[AW-1:0];
            tail_d     = tail_q + AW'(acc);
            count_d    = count_q + CW'(acc) - deq;
            overflow_d = overflow_q | (CW'(enq) > free_slots);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign tail_inc = tail_q + AW'(1);

    // Entry storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr0) mem_q[tail_q]   <= slot0;
        if (wr1) mem_q[tail_inc] <= slot1;
    end

    assign head_inc = head_q + AW'(1);
    assign e0       = mem_q[head_q];
    assign e1       = mem_q[head_inc];

    assign D0V  = (count_q != '0);
    assign D1V  = (count_q > CW'(1));
    assign D0   = D0V ? e0[32:17] : 16'h0;
    assign D0P  = D0V ? e0[16]    : 1'b0;
    assign D0PC = D0V ? e0[15:0]  : 16'h0;
    assign D1   = D1V ? e1[32:17] : 16'h0;
    assign D1P  = D1V ? e1[16]    : 1'b0;
    assign D1PC = D1V ? e1[15:0]  : 16'h0;

    assign stall    = (CW'(DEPTH) - count_q) < CW'(4);
    assign count    = count_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   I1, I2, I1PC, I2PC;
    logic          I1V, I2V, I1P, I2P;
    logic          flush;
    logic [1:0]    take;
    logic [15:0]   D0, D1, D0PC, D1PC;
    logic          D0V, D1V, D0P, D1P;
    logic          stall;
    logic [CW-1:0] count;
    logic          overflow;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .I1(I1), .I2(I2), .I1V(I1V), .I2V(I2V), .I1P(I1P), .I2P(I2P),
        .I1PC(I1PC), .I2PC(I2PC), .flush(flush), .take(take),
        .D0(D0), .D1(D1), .D0V(D0V), .D1V(D1V), .D0P(D0P), .D1P(D1P),
        .D0PC(D0PC), .D1PC(D1PC), .stall(stall), .count(count), .overflow(overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: entries {instr, P, PC}, oldest first
    logic [32:0] exp_q[$];
    logic        ovf_m;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] pc_ctr = 16'h0100;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int d;
        if (flush) begin
            exp_q.delete();
            return;
        end
        d = (take == 2'd3) ? 2 : int'(take);
        if (d > exp_q.size()) d = exp_q.size();
        repeat (d) void'(exp_q.pop_front());
        if (I1V) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({I1, I1P, I1PC});
            else ovf_m = 1'b1;
        end
        if (I2V) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({I2, I2P, I2PC});
            else ovf_m = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [32:0] e0, e1;
        int          sz;
        sz = exp_q.size();
        e0 = (sz >= 1) ? exp_q[0] : 33'h0;
        e1 = (sz >= 2) ? exp_q[1] : 33'h0;
        check("count", 64'(count), 64'(sz));
        check("d0v",   64'(D0V),   64'(sz >= 1));
        check("d1v",   64'(D1V),   64'(sz >= 2));
        check("d0",    64'({D0, D0P, D0PC}), 64'(e0));
        check("d1",    64'({D1, D1P, D1PC}), 64'(e1));
        check("stall", 64'(stall), 64'((DEPTH - sz) < 4));
        check("ovf",   64'(overflow), 64'(ovf_m));
    endtask

    // driver tasks
    task automatic drive(input logic v1, input logic [15:0] i1, input logic [15:0] pc1,
                         input logic v2, input logic [15:0] i2, input logic [15:0] pc2,
                         input logic [1:0] tk, input logic fl);
        I1V = v1; I1 = i1; I1PC = pc1; I1P = 1'($urandom_range(0, 1));
        I2V = v2; I2 = i2; I2PC = pc2; I2P = 1'($urandom_range(0, 1));
        take = tk; flush = fl;
    endtask

    task automatic idle(input logic [1:0] tk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, tk, 1'b0);
    endtask

    task automatic pair(input logic [1:0] tk);
        drive(1'b1, 16'($urandom), pc_ctr, 1'b1, 16'($urandom), pc_ctr + 16'd2, tk, 1'b0);
        pc_ctr = pc_ctr + 16'd4;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic reset_mid_cycle();
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        ovf_m = 1'b0;
        check("rst_async_count", 64'(count), 64'(0));
        check("rst_async_d0v",   64'(D0V),   64'(0));
        check("rst_async_d0",    64'(D0),    64'(0));
        check("rst_async_ovf",   64'(overflow), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ovf_m = 1'b0;
        idle(2'd0);
        #12;
        check_all();
        check("rst_stall", 64'(stall), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // two-slot enqueue into an empty queue
        drive(1'b1, 16'h1111, 16'h0000, 1'b1, 16'h2222, 16'h0002, 2'd0, 1'b0);
        step();
        check("basic_d0",   64'(D0),   64'(16'h1111));
        check("basic_d1",   64'(D1),   64'(16'h2222));
        check("basic_d1pc", 64'(D1PC), 64'(16'h0002));
        check("basic_cnt",  64'(count), 64'(2));
        idle(2'd3); step();
        check("drain_empty", 64'(count), 64'(0));

        // only the second slot valid
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'hABCD, 16'h0010, 2'd0, 1'b0);
        step();
        check("single_d0",  64'(D0),  64'(16'hABCD));
        check("single_d1v", 64'(D1V), 64'(0));
        idle(2'd1); step();

        // fill to full while watching back-pressure
        for (int i = 1; i <= 4; i++) begin
            pair(2'd0); step();
            check("fill_stall", 64'(stall), 64'((2 * i) >= 5));
        end
        check("full_cnt", 64'(count), 64'(8));
        check("full_ovf", 64'(overflow), 64'(0));
        idle(2'd0); step();

        // overflow: one slot freed, two offered
        pair(2'd1); step();
        check("ovf_cnt",  64'(count), 64'(8));
        check("ovf_flag", 64'(overflow), 64'(1));
        idle(2'd2); step();
        idle(2'd1); step();
        check("pre_flush_cnt", 64'(count), 64'(5));

        // flush overrides take and inputs
        pair(2'd2);
        flush = 1'b1;
        step();
        check("flush_cnt",   64'(count), 64'(0));
        check("flush_stall", 64'(stall), 64'(0));
        check("flush_sticky_ovf", 64'(overflow), 64'(1));
        pair(2'd0); step();
        check("post_flush_cnt", 64'(count), 64'(2));

        // steady 2-in/2-out across pointer wrap
        for (int i = 0; i < 10; i++) begin
            pair(2'd2); step();
            check("wrap_cnt",   64'(count), 64'(2));
            check("wrap_order", 64'(D1PC), 64'(D0PC + 16'd2));
        end
        idle(2'd2); step();
        idle(2'd2); step();
        check("empty_take_cnt", 64'(count), 64'(0));

        // reset while entries are queued
        pair(2'd0); step();
        reset_mid_cycle();
        idle(2'd0); step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic v1, v2;
            v1 = 1'($urandom_range(0, 1));
            v2 = 1'($urandom_range(0, 1));
            drive(v1, 16'($urandom), pc_ctr, v2, 16'($urandom), pc_ctr + 16'd2,
                  2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
            pc_ctr = pc_ctr + 16'd4;
            step();
            if (i == 200) begin
                reset_mid_cycle();
                idle(2'd0); step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
